serbus_fsm: RTL and testbench

SERBUS_FSM -- requirements
Module: serbus_fsm

---
 rtl/serbus_pkg.sv | 32 +++
 rtl/serbus_rx.sv | 37 +++
 rtl/serbus_fsm.sv | 243 ++++++++++++++++++++++++
 tb/tb_serbus_fsm.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serbus_pkg.sv
// serbus_pkg -- shared definitions for the serial register-bus bridge.
//
// Holds the command/reply codes, the FSM state encoding, the reply frame
// length and the receive shift-register width, plus a helper that builds
// one 13-bit reply frame (MSb first: 0, 1, cmdflag, data[7:0], 0, 0).
package serbus_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_PING  = 8'h03;
    localparam logic [7:0] ERR_CODE  = 8'hFF;

    localparam int REPLY_BITS = 13;
    localparam int RXREG_W    = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECODE  = 3'd1,
        WRITE   = 3'd2,
        READ    = 3'd3,
        RWAIT   = 3'd4,
        CAPTURE = 3'd5,
        REPLY   = 3'd6,
        DONE    = 3'd7
    } state_e;

    function automatic logic [REPLY_BITS-1:0] reply_frame(input logic cmdflag,
                                                          input logic [7:0] data);
        return {2'b01, cmdflag, data, 2'b00};
    endfunction

endpackage

// File: rtl/serbus_rx.sv
// serbus_rx -- receive deframer.
//
// Shifts serialin into the LSB of a 12-bit register every cycle. A frame
// is recognised when the marker 1 reaches the top bit and the two trailing
// bits are 0; the 9 bits in between (cmdflag + 8 data bits) are presented
// for one cycle and the register clears. The input bit of that cycle is the
// next frame's leading 0, so back-to-back 13-bit frames are handled.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   serialin     framed command stream
//   byte_valid   one-cycle pulse, rx_byte valid
//   rx_byte      {cmdflag, data[7:0]}
module serbus_rx
    import serbus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serialin,
    output logic       byte_valid,
    output logic [8:0] rx_byte
);

    logic [RXREG_W-1:0] sr_q, sr_d;

    always_comb begin
        byte_valid = sr_q[RXREG_W-1] && (sr_q[1:0] == 2'b00);
        rx_byte    = sr_q[RXREG_W-2:2];
        sr_d       = byte_valid ? '0 : {sr_q[RXREG_W-2:0], serialin};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end

endmodule

// File: rtl/serbus_fsm.sv
// serbus_fsm -- serial command stream to register-bus bridge.
//
// Data bytes are collected in a message buffer; a command byte starts the
// FSM, which issues a one-cycle wr or rd strobe and returns a framed reply
// on serialout. Reply bits come straight from the MSB of a reply shift
// register, so serialout is a flop and reads 0 whenever no reply is queued.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   serialin/serialout  framed command / reply streams
//   wr, rd              one-cycle strobes; addr, wrdata held until next DECODE
//   rddata              read data, sampled RDLAT cycles after rd
//   busy                FSM not in IDLE
//   rdcount..errcount   statistics counters (16-bit, wrapping)
//   dbg_state           current FSM state
//
// Build option: define SERBUS_STATS_EN to include the statistics counters;
// without it the four counter outputs are tied to 0.
module serbus_fsm
    import serbus_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int RDLAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          serialin,
    output logic          serialout,
    output logic          wr,
    output logic          rd,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wrdata,
    input  logic [DW-1:0] rddata,
    output logic          busy,
    output logic [15:0]   rdcount,
    output logic [15:0]   wrcount,
    output logic [15:0]   bytecount,
    output logic [15:0]   errcount,
    output logic [2:0]    dbg_state
);

    localparam int NB   = (AW + DW) / 8;
    localparam int DB   = DW / 8;
    localparam int RW   = REPLY_BITS * (DB + 1);
    localparam int CW   = 4;
    localparam int LW   = 7;
    localparam logic [CW-1:0] CNT_MAX = CW'(NB + 1);
    localparam logic [LW-1:0] LEN_ONE = LW'(REPLY_BITS);
    localparam logic [LW-1:0] LEN_RD  = LW'(RW);

    logic       byte_valid;
    logic [8:0] rx_byte;

    serbus_rx u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .serialin   (serialin),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte)
    );

    state_e            state_q, state_d;
    logic [NB*8-1:0]   buf_q, buf_d;
    logic [CW-1:0]     cnt_q, cnt_d, cmd_cnt_q, cmd_cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              clr_q, clr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wrdata_q, wrdata_d;
    logic [3:0]        wait_q, wait_d;
    logic [RW-1:0]     rep_q, rep_d, rd_reply;
    logic [LW-1:0]     rep_left_q, rep_left_d;
    logic              exec, dec_write, dec_read, dec_ping;

    assign exec      = byte_valid && rx_byte[8] && (state_q == IDLE);
    assign dec_write = (cmd_q == CMD_WRITE) && (cmd_cnt_q == CW'(NB));
    assign dec_read  = (cmd_q == CMD_READ)  && (cmd_cnt_q == CW'(AW / 8));
    assign dec_ping  = (cmd_q == CMD_PING);

    // Message buffer. Any command byte schedules a buffer clear for the next
    // cycle, which leaves the contents intact for the DECODE cycle that
    // follows an accepted command.
    always_comb begin
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        cmd_cnt_d = cmd_cnt_q;
        clr_d     = 1'b0;
        if (clr_q) begin
            buf_d = '0;
            cnt_d = '0;
        end
        if (byte_valid) begin
            if (!rx_byte[8]) begin
                buf_d = {buf_q[NB*8-9:0], rx_byte[7:0]};
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
                clr_d = 1'b1;
                if (exec) begin
                    cmd_d     = rx_byte[7:0];
                    cmd_cnt_d = cnt_q;
                end
            end
        end
    end

    // Read reply: data bytes MSB first with cmdflag 0, then the read code.
    always_comb begin
        rd_reply = '0;
        for (int i = 0; i < DB; i++) begin
            rd_reply[RW-1-REPLY_BITS*i -: REPLY_BITS] = reply_frame(1'b0, rddata[DW-1-8*i -: 8]);
        end
        rd_reply[REPLY_BITS-1:0] = reply_frame(1'b1, CMD_READ);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wrdata_d   = wrdata_q;
        wait_d     = wait_q;
        rep_left_d = rep_left_q;
        rep_d      = (state_q == REPLY) ? {rep_q[RW-2:0], 1'b0} : rep_q;
        case (state_q)
            IDLE: if (exec) state_d = DECODE;
            DECODE: begin
                if (dec_write) begin
                    addr_d   = buf_q[AW-1:0];
                    wrdata_d = buf_q[AW+DW-1:AW];
                    state_d  = WRITE;
                end else if (dec_read) begin
                    addr_d  = buf_q[AW-1:0];
                    state_d = READ;
                end else begin
                    rep_d      = {reply_frame(1'b1, dec_ping ? CMD_PING : ERR_CODE),
                                  {(RW-REPLY_BITS){1'b0}}};
                    rep_left_d = LEN_ONE;
                    state_d    = REPLY;
                end
            end
            WRITE: begin
                rep_d      = {reply_frame(1'b1, CMD_WRITE), {(RW-REPLY_BITS){1'b0}}};
                rep_left_d = LEN_ONE;
                state_d    = REPLY;
            end
            READ: begin
                wait_d  = 4'(RDLAT - 1);
                state_d = (RDLAT == 1) ? CAPTURE : RWAIT;
            end
            RWAIT: begin
                if (wait_q <= 4'd1) state_d = CAPTURE;
                else                wait_d  = wait_q - 4'd1;
            end
            CAPTURE: begin
                rep_d      = rd_reply;
                rep_left_d = LEN_RD;
                state_d    = REPLY;
            end
            REPLY: begin
                rep_left_d = rep_left_q - 1'b1;
                if (rep_left_q == 1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            cnt_q      <= '0;
            cmd_q      <= '0;
            cmd_cnt_q  <= '0;
            clr_q      <= 1'b0;
            addr_q     <= '0;
            wrdata_q   <= '0;
            wait_q     <= '0;
            rep_q      <= '0;
            rep_left_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            cmd_cnt_q  <= cmd_cnt_d;
            clr_q      <= clr_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
            wait_q     <= wait_d;
            rep_q      <= rep_d;
            rep_left_q <= rep_left_d;
        end
    end

    assign serialout = rep_q[RW-1];
    assign wr        = (state_q == WRITE);
    assign rd        = (state_q == READ);
    assign busy      = (state_q != IDLE);
    assign addr      = addr_q;
    assign wrdata    = wrdata_q;
    assign dbg_state = state_q;

`ifdef SERBUS_STATS_EN
    logic [15:0] rdcount_q, rdcount_d, wrcount_q, wrcount_d;
    logic [15:0] bytecount_q, bytecount_d, errcount_q, errcount_d;
    logic        err_ev, drop;

    always_comb begin
        // Errors: an undecodable command, or a command byte arriving while busy.
        err_ev      = (state_q == DECODE) && !dec_write && !dec_read && !dec_ping;
        drop        = byte_valid && rx_byte[8] && (state_q != IDLE);
        rdcount_d   = rdcount_q + 16'(state_q == CAPTURE);
        wrcount_d   = wrcount_q + 16'(state_q == WRITE);
        bytecount_d = bytecount_q + 16'(byte_valid);
        errcount_d  = errcount_q + 16'(err_ev) + 16'(drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdcount_q   <= '0;
            wrcount_q   <= '0;
            bytecount_q <= '0;
            errcount_q  <= '0;
        end else begin
            rdcount_q   <= rdcount_d;
            wrcount_q   <= wrcount_d;
            bytecount_q <= bytecount_d;
            errcount_q  <= errcount_d;
        end
    end

    assign rdcount   = rdcount_q;
    assign wrcount   = wrcount_q;
    assign bytecount = bytecount_q;
    assign errcount  = errcount_q;
`else
    assign rdcount   = '0;
    assign wrcount   = '0;
    assign bytecount = '0;
    assign errcount  = '0;
`endif

endmodule

// File: tb/tb_serbus_fsm.sv
// tb_serbus_fsm -- directed bench for serbus_fsm.
//
// Two instances: dut0 (AW=DW=16, RDLAT=2) and dut1 (AW=32, DW=8, RDLAT=3).
// Each table record lists the bytes sent, the command, the read data, and
// the expected reply stream (busy-window bits), strobes and counter deltas.
// Counter expectations follow SERBUS_STATS_EN: 0 when it is not defined.
module tb_serbus_fsm;

`ifdef SERBUS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        serialin0, serialout0, wr0, rd0, busy0;
    logic [15:0] addr0, wrdata0, rddata0, rdval0;
    logic [15:0] rdc0, wrc0, bc0, ec0;
    logic [2:0]  dbg0;

    logic        serialin1, serialout1, wr1, rd1, busy1;
    logic [31:0] addr1;
    logic [7:0]  wrdata1, rddata1, rdval1;
    logic [15:0] rdc1, wrc1, bc1, ec1;
    logic [2:0]  dbg1;

    serbus_fsm #(.AW(16), .DW(16), .RDLAT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .serialin(serialin0), .serialout(serialout0),
        .wr(wr0), .rd(rd0), .addr(addr0), .wrdata(wrdata0), .rddata(rddata0),
        .busy(busy0), .rdcount(rdc0), .wrcount(wrc0), .bytecount(bc0),
        .errcount(ec0), .dbg_state(dbg0)
    );

    serbus_fsm #(.AW(32), .DW(8), .RDLAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .serialin(serialin1), .serialout(serialout1),
        .wr(wr1), .rd(rd1), .addr(addr1), .wrdata(wrdata1), .rddata(rddata1),
        .busy(busy1), .rdcount(rdc1), .wrcount(wrc1), .bytecount(bc1),
        .errcount(ec1), .dbg_state(dbg1)
    );

    // ---------------- selected-DUT view ----------------
    int          sel;
    logic        busy_m, so_m, wr_m, rd_m;
    logic [31:0] addr_m, wrdata_m;
    logic [15:0] cnt_m [4];

    always_comb begin
        if (sel == 0) begin
            busy_m = busy0; so_m = serialout0; wr_m = wr0; rd_m = rd0;
            addr_m = {16'h0, addr0}; wrdata_m = {16'h0, wrdata0};
            cnt_m[0] = rdc0; cnt_m[1] = wrc0; cnt_m[2] = bc0; cnt_m[3] = ec0;
        end else begin
            busy_m = busy1; so_m = serialout1; wr_m = wr1; rd_m = rd1;
            addr_m = addr1; wrdata_m = {24'h0, wrdata1};
            cnt_m[0] = rdc1; cnt_m[1] = wrc1; cnt_m[2] = bc1; cnt_m[3] = ec1;
        end
    end

    // Read data is valid only in the cycle RDLAT after rd; inverted otherwise.
    logic [15:0] hist0, hist1;
    initial begin
        hist0 = '0; hist1 = '0; rdval0 = '0; rdval1 = '0;
        rddata0 = '1; rddata1 = '1;
    end
    always @(negedge clk) begin
        hist0 = {hist0[14:0], rd0};
        hist1 = {hist1[14:0], rd1};
        rddata0 = hist0[2] ? rdval0 : ~rdval0;
        rddata1 = hist1[3] ? rdval1 : ~rdval1;
    end

    // ---------------- monitor ----------------
    logic        obs_q[$];
    int          wr_seen, rd_seen, rises, so_idle_hi;
    logic [31:0] seen_addr, seen_wrdata;
    logic        busy_prev;
    initial begin
        wr_seen = 0; rd_seen = 0; rises = 0; so_idle_hi = 0;
        seen_addr = '0; seen_wrdata = '0; busy_prev = 1'b0;
    end
    always @(negedge clk) begin
        if (busy_m) begin
            obs_q.push_back(so_m);
            if (!busy_prev) rises++;
        end else if (so_m) begin
            so_idle_hi++;
        end
        if (wr_m) begin wr_seen++; seen_addr = addr_m; seen_wrdata = wrdata_m; end
        if (rd_m) begin rd_seen++; seen_addr = addr_m; end
        busy_prev = busy_m;
    end

    // ---------------- scoreboard ----------------
    int checks, failures;
    int exp_c [2][4];   // rd, wr, byte, err
    logic exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          sel;
        int          nd;
        logic [47:0] d;        // byte i at d[47-8*i -: 8]
        logic [7:0]  cmd;
        logic [15:0] rdval;
        int          pre;      // busy cycles before the first reply bit
        int          nrep;
        logic [26:0] rep;      // up to three {cmdflag, byte} entries, first at top
        int          wr_n;
        int          rd_n;
        logic [31:0] exp_addr;
        logic [31:0] exp_wrdata;
        int          err;
    } vec_t;

    function automatic vec_t mk(int s, int nd, logic [47:0] d, logic [7:0] cmd,
                                logic [15:0] rv, int pre, int nrep, logic [26:0] rep,
                                int wn, int rn, logic [31:0] a, logic [31:0] w, int e);
        vec_t v;
        v.sel = s; v.nd = nd; v.d = d; v.cmd = cmd; v.rdval = rv; v.pre = pre;
        v.nrep = nrep; v.rep = rep; v.wr_n = wn; v.rd_n = rn; v.exp_addr = a;
        v.exp_wrdata = w; v.err = e;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic flag, input logic [7:0] b);
        logic [12:0] f;
        f = {2'b01, flag, b, 2'b00};
        for (int i = 12; i >= 0; i--) begin
            @(posedge clk); #1;
            if (sel == 0) serialin0 = f[i];
            else          serialin1 = f[i];
        end
    endtask

    task automatic start_vec(input vec_t v);
        sel = v.sel;
        rdval0 = v.rdval;
        rdval1 = v.rdval[7:0];
        obs_q.delete();
        wr_seen = 0; rd_seen = 0; rises = 0; so_idle_hi = 0;
        for (int i = 0; i < v.nd; i++) send_frame(1'b0, v.d[47-8*i -: 8]);
        send_frame(1'b1, v.cmd);
    endtask

    task automatic wait_idle(output bit ok);
        bit seen;
        seen = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy_m) seen = 1'b1;
            else if (seen) begin ok = 1'b1; break; end
        end
    endtask

    task automatic finish_vec(input int idx, input vec_t v, input int extra);
        bit ok;
        int nbad, n;
        logic [8:0] e;
        wait_idle(ok);
        chk($sformatf("v%0d_done", idx), 32'(ok), 32'd1);
        exp_q.delete();
        for (int i = 0; i < v.pre; i++) exp_q.push_back(1'b0);
        for (int k = 0; k < v.nrep; k++) begin
            e = v.rep[26-9*k -: 9];
            exp_q.push_back(1'b0);
            exp_q.push_back(1'b1);
            for (int b = 8; b >= 0; b--) exp_q.push_back(e[b]);
            exp_q.push_back(1'b0);
            exp_q.push_back(1'b0);
        end
        exp_q.push_back(1'b0);
        chk($sformatf("v%0d_busy_len", idx), 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        nbad = 0;
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) nbad++;
        chk($sformatf("v%0d_reply_badbits", idx), 32'(nbad), 32'd0);
        chk($sformatf("v%0d_wr_pulses", idx), 32'(wr_seen), 32'(v.wr_n));
        chk($sformatf("v%0d_rd_pulses", idx), 32'(rd_seen), 32'(v.rd_n));
        if (v.wr_n > 0 || v.rd_n > 0) chk($sformatf("v%0d_addr", idx), seen_addr, v.exp_addr);
        if (v.wr_n > 0) chk($sformatf("v%0d_wrdata", idx), seen_wrdata, v.exp_wrdata);
        chk($sformatf("v%0d_busy_rises", idx), 32'(rises), 32'd1);
        chk($sformatf("v%0d_so_idle", idx), 32'(so_idle_hi), 32'd0);
        exp_c[v.sel][0] += v.rd_n;
        exp_c[v.sel][1] += v.wr_n;
        exp_c[v.sel][2] += v.nd + 1 + extra;
        exp_c[v.sel][3] += v.err;
        for (int k = 0; k < 4; k++)
            chk($sformatf("v%0d_cnt%0d", idx, k), {16'h0, cnt_m[k]},
                STATS ? 32'(exp_c[v.sel][k] % 65536) : 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        start_vec(v);
        finish_vec(idx, v, 0);
    endtask

    // ---------------- test ----------------
    vec_t tbl[13];
    vec_t vd, vp;
    bit   ok;

    initial begin
        checks = 0; failures = 0; sel = 0;
        serialin0 = 1'b0; serialin1 = 1'b0; rst_n = 1'b0;
        for (int s = 0; s < 2; s++) for (int k = 0; k < 4; k++) exp_c[s][k] = 0;

        //              sel nd data                                       cmd    rdval    pre nrep rep                             wr rd addr          wrdata        err
        tbl[0]  = mk(0, 4, {8'hBE, 8'hEF, 8'h00, 8'h10, 16'h0},           8'h01, 16'h0,    2, 1, {9'h101, 18'h0},                1, 0, 32'h0010,     32'hBEEF,     0);
        tbl[1]  = mk(0, 2, {8'h00, 8'h10, 32'h0},                         8'h02, 16'h1234, 4, 3, {9'h012, 9'h034, 9'h102},       0, 1, 32'h0010,     32'h0,        0);
        tbl[2]  = mk(0, 2, {8'hAB, 8'hCD, 32'h0},                         8'h01, 16'h0,    1, 1, {9'h1FF, 18'h0},                0, 0, 32'h0,        32'h0,        1);
        tbl[3]  = mk(0, 0, 48'h0,                                         8'h03, 16'h0,    1, 1, {9'h103, 18'h0},                0, 0, 32'h0,        32'h0,        0);
        tbl[4]  = mk(0, 4, {8'h12, 8'h34, 8'h56, 8'h78, 16'h0},           8'h01, 16'h0,    2, 1, {9'h101, 18'h0},                1, 0, 32'h5678,     32'h1234,     0);
        tbl[5]  = mk(0, 5, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h0},     8'h01, 16'h0,    1, 1, {9'h1FF, 18'h0},                0, 0, 32'h0,        32'h0,        1);
        tbl[6]  = mk(0, 6, 48'h010203040506,                              8'h01, 16'h0,    1, 1, {9'h1FF, 18'h0},                0, 0, 32'h0,        32'h0,        1);
        tbl[7]  = mk(0, 4, {8'h00, 8'h10, 8'h00, 8'h20, 16'h0},           8'h02, 16'h0,    1, 1, {9'h1FF, 18'h0},                0, 0, 32'h0,        32'h0,        1);
        tbl[8]  = mk(0, 0, 48'h0,                                         8'h81, 16'h0,    1, 1, {9'h1FF, 18'h0},                0, 0, 32'h0,        32'h0,        1);
        tbl[9]  = mk(0, 2, {8'hA5, 8'h5A, 32'h0},                         8'h02, 16'hFFFF, 4, 3, {9'h0FF, 9'h0FF, 9'h102},       0, 1, 32'hA55A,     32'h0,        0);
        tbl[10] = mk(1, 5, {8'hA7, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0},     8'h01, 16'h0,    2, 1, {9'h101, 18'h0},                1, 0, 32'hDEADBEEF, 32'hA7,       0);
        tbl[11] = mk(1, 4, {8'h01, 8'h02, 8'h03, 8'h04, 16'h0},           8'h02, 16'h00C3, 5, 2, {9'h0C3, 9'h102, 9'h0},         0, 1, 32'h01020304, 32'h0,        0);
        tbl[12] = mk(1, 4, {8'h01, 8'h02, 8'h03, 8'h04, 16'h0},           8'h01, 16'h0,    1, 1, {9'h1FF, 18'h0},                0, 0, 32'h0,        32'h0,        1);

        // Reset state, sampled while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_so0", 32'(serialout0), 32'd0);
        chk("rst_wr0", 32'(wr0), 32'd0);
        chk("rst_rd0", 32'(rd0), 32'd0);
        chk("rst_addr0", {16'h0, addr0}, 32'h0);
        chk("rst_wrdata0", {16'h0, wrdata0}, 32'h0);
        chk("rst_bc0", {16'h0, bc0}, 32'h0);
        chk("rst_ec0", {16'h0, ec0}, 32'h0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_addr1", addr1, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 13; i++) begin
            run_vec(i, tbl[i]);
            repeat (3) @(posedge clk);
        end

        // Command byte arriving during a read reply: reply intact, command dropped.
        vd = mk(0, 2, {8'h00, 8'h10, 32'h0}, 8'h02, 16'hC0DE, 4, 3,
                {9'h0C0, 9'h0DE, 9'h102}, 0, 1, 32'h0010, 32'h0, 1);
        start_vec(vd);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy0) begin ok = 1'b1; break; end
        end
        chk("drop_busy_rise", 32'(ok), 32'd1);
        repeat (8) @(posedge clk);
        send_frame(1'b1, 8'h03);
        finish_vec(20, vd, 1);
        repeat (40) @(posedge clk);
        chk("drop_no_second_reply", 32'(rises), 32'd1);

        // Reset in the middle of a reply.
        sel = 0;
        send_frame(1'b1, 8'h03);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy0) begin ok = 1'b1; break; end
        end
        chk("rstrep_busy_rise", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        chk("rstrep_so_before", 32'(serialout0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstrep_so_after", 32'(serialout0), 32'd0);
        chk("rstrep_busy_after", 32'(busy0), 32'd0);
        chk("rstrep_bc_after", {16'h0, bc0}, 32'h0);
        for (int s = 0; s < 2; s++) for (int k = 0; k < 4; k++) exp_c[s][k] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rstrep_so_idle", 32'(serialout0), 32'd0);
        vp = mk(0, 0, 48'h0, 8'h03, 16'h0, 1, 1, {9'h103, 18'h0}, 0, 0, 32'h0, 32'h0, 0);
        run_vec(21, vp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
